ntt_masked_pwm_sched: RTL and testbench
=======================================

# ntt_masked_pwm_sched

Address and timing sequencer that sits directly upstream of the masked point-wise multiply (PWM/PWMA) datapath. On `start` it streams 256 coefficient-pair read requests for the u/v operand memory. In accumulate mode it issues w-operand reads, time-aligned to the multiplier's adder stage. It issues result writes when the masked pipeline output becomes valid, then pulses `done`. It owns all latency bookkeeping so the masked datapath can remain a free-running, unstalled pipeline.

## Interface
- `NUM_COEFF`, 256: coefficients per polynomial, one per read/write.
- `ADDR_WIDTH`, 8: memory address width.
- `RD_LAT`, 1: memory read latency in cycles, from rd_en to data at the datapath input.
- `MUL_LAT`, 210: masked multiply latency, from u/v input to product.
- `ACC_LAT`, 264: masked multiply-accumulate latency, from u/v input to result.
- `CNT_WIDTH`, 10: width of the cycle counter; must hold `RD_LAT+ACC_LAT+NUM_COEFF`.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `zeroize`  in  1  synchronous clear; aborts any operation.
- `start`  in  1  single-cycle request, sampled only in IDLE.
- `accumulate`  in  1  mode select, sampled with start: 1 = PWMA, 0 = PWM.
- `uv_base`, `w_base`, `dst_base`  in  ADDR_WIDTH each  base addresses, sampled with start.
- `uv_rd_en` / `uv_rd_addr`  out  1 / ADDR_WIDTH  u/v operand read.
- `w_rd_en` / `w_rd_addr`  out  1 / ADDR_WIDTH  w operand read (PWMA only).
- `wr_en` / `wr_addr`  out  1 / ADDR_WIDTH  result write strobe and address.
- `pwm_accumulate`  out  1  latched mode, drives the datapath accumulate select.
- `rnd_en`  out  1  randomness-refresh enable for the masking PRNG.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- The FSM has three states.
  - IDLE: on `start`, latch `accumulate`, `uv_base`, `w_base` and `dst_base`; clear `cyc`; go to RUN.
  - RUN: increment `cyc` every cycle. Define `END = RD_LAT + (acc ? ACC_LAT : MUL_LAT) + NUM_COEFF − 1`. When `cyc == END`, go to DONE.
  - DONE: assert `done` for one cycle, then return to IDLE.
- `cyc` is the cycle index within RUN; the first RUN cycle is `cyc = 0`.
- u/v reads: `uv_rd_en = RUN && cyc < NUM_COEFF`. `uv_rd_addr = uv_base + cyc`, mod 2^ADDR_WIDTH.
- w reads:
  - Define `WOFS = MUL_LAT + 1`.
  - `w_rd_en = RUN && acc && WOFS ≤ cyc < WOFS + NUM_COEFF`.
  - `w_rd_addr = w_base + (cyc − WOFS)`, mod 2^ADDR_WIDTH.
  - This offset places w at the adder input in the same cycle as the registered product of the same index.
- Writes:
  - Define `WROFS = RD_LAT + (acc ? ACC_LAT : MUL_LAT)`.
  - `wr_en = RUN && WROFS ≤ cyc < WROFS + NUM_COEFF`.
  - `wr_addr = dst_base + (cyc − WROFS)`, mod 2^ADDR_WIDTH.
- Address arithmetic wraps silently modulo 2^ADDR_WIDTH; there is no error on wrap.
- `pwm_accumulate` holds the latched mode from `start` until the next `start` is accepted. It is cleared only by reset or zeroize.
- `rnd_en` equals RUN, so randomness is consumed only while operands are in flight.
- `start` asserted during RUN or DONE is ignored; there is no queueing.
- `start` and `zeroize` asserted in the same cycle: zeroize wins, and the FSM stays in IDLE.
- Parameter, start-input and `accumulate` changes during RUN have no effect, because all of them are latched at start.

## Timing
- Reset (`reset_n` low) or `zeroize`: state goes to IDLE, `cyc = 0`, and all latched values are 0.
- Every output is 0 after reset or zeroize: `uv_rd_en`, `w_rd_en`, `wr_en`, all addresses, `pwm_accumulate`, `rnd_en`, `busy`, `done`.
- All outputs are registered-state decodes with no combinational path from `start`.
  - The first `uv_rd_en` appears the cycle after `start` is sampled.
- Zeroize mid-operation:
  - All enables fall the following cycle.
  - No `done` pulse is produced; the partial operation is discarded.
- Start-to-done timing, with `start` sampled at edge 0:
  - PWM: `done` at cycle 468.
  - PWMA: `done` at cycle 522.
- The next `start` is accepted in the cycle after `done`.
- Back-to-back operations have a turnaround cost of 2 idle cycles (DONE state plus the IDLE sample cycle).

## Test plan
- PWM, `uv_base = 0x10`, `dst_base = 0x80`, `start` at cycle 0:
  - `uv_rd_en` is high for cycles 1–256, with addresses 0x10…0x0F (wrapping).
  - `w_rd_en` is never asserted.
  - `wr_en` is high for cycles 212–467, with addresses 0x80…0x7F.
  - `done` pulses at cycle 468; `pwm_accumulate = 0`.
- PWMA, `w_base = 0x40`, `start` at cycle 0:
  - `w_rd_en` is high for cycles 212–467, with addresses 0x40…0x3F.
  - `wr_en` is high for cycles 266–521.
  - `done` pulses at cycle 522; `pwm_accumulate = 1` throughout.
- `start` re-asserted at cycle 100 of a PWM run: ignored. Exactly 256 writes occur, with a single `done` at cycle 468.
- `zeroize` at cycle 300 of a PWMA run:
  - All outputs are 0 from cycle 301.
  - `done` is never asserted.
  - A new `start` at cycle 305 runs a complete operation.
- Reset asserted asynchronously at cycle 50: outputs go to 0 immediately, with no `done`; the FSM is IDLE after release.
- `start` and `zeroize` in the same cycle: no operation begins and `busy` stays 0.

Source files
------------

// File: rtl/ntt_masked_pwm_sched.sv
// Address/timing sequencer feeding the masked PWM/PWMA datapath: streams u/v reads,
// aligned w reads (accumulate mode) and result writes, then pulses done.
module ntt_masked_pwm_sched #(
  parameter int unsigned NUM_COEFF  = 256,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned MUL_LAT    = 210,
  parameter int unsigned ACC_LAT    = 264,
  parameter int unsigned CNT_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  zeroize,
  input  logic                  start,
  input  logic                  accumulate,
  input  logic [ADDR_WIDTH-1:0] uv_base,
  input  logic [ADDR_WIDTH-1:0] w_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  output logic                  uv_rd_en,
  output logic [ADDR_WIDTH-1:0] uv_rd_addr,
  output logic                  w_rd_en,
  output logic [ADDR_WIDTH-1:0] w_rd_addr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  pwm_accumulate,
  output logic                  rnd_en,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CNT_WIDTH-1:0] C_NUM      = CNT_WIDTH'(NUM_COEFF);
  localparam logic [CNT_WIDTH-1:0] C_WOFS     = CNT_WIDTH'(MUL_LAT + 1);
  localparam logic [CNT_WIDTH-1:0] C_WOFS_END = CNT_WIDTH'(MUL_LAT + 1 + NUM_COEFF);
  localparam logic [CNT_WIDTH-1:0] C_WRO_M    = CNT_WIDTH'(RD_LAT + MUL_LAT);
  localparam logic [CNT_WIDTH-1:0] C_WRO_A    = CNT_WIDTH'(RD_LAT + ACC_LAT);
  localparam logic [CNT_WIDTH-1:0] C_WRE_M    = CNT_WIDTH'(RD_LAT + MUL_LAT + NUM_COEFF);
  localparam logic [CNT_WIDTH-1:0] C_WRE_A    = CNT_WIDTH'(RD_LAT + ACC_LAT + NUM_COEFF);
  localparam logic [CNT_WIDTH-1:0] C_END_M    = CNT_WIDTH'(RD_LAT + MUL_LAT + NUM_COEFF - 1);
  localparam logic [CNT_WIDTH-1:0] C_END_A    = CNT_WIDTH'(RD_LAT + ACC_LAT + NUM_COEFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_WIDTH-1:0]    r_cyc;
  logic [CNT_WIDTH-1:0]    w_cyc_nxt;
  logic                    w_latch;
  logic                    r_acc;
  logic [ADDR_WIDTH-1:0]   r_uv_base;
  logic [ADDR_WIDTH-1:0]   r_w_base;
  logic [ADDR_WIDTH-1:0]   r_dst_base;

  logic                    w_run;
  logic [CNT_WIDTH-1:0]    w_end;
  logic [CNT_WIDTH-1:0]    w_wro;
  logic [CNT_WIDTH-1:0]    w_wre;

  assign w_end = r_acc ? C_END_A : C_END_M;
  assign w_wro = r_acc ? C_WRO_A : C_WRO_M;
  assign w_wre = r_acc ? C_WRE_A : C_WRE_M;

  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_cyc_nxt   = '0;
          w_latch     = 1'b1;
        end
      end
      S_RUN: begin
        w_cyc_nxt = r_cyc + 1'b1;
        if (r_cyc == w_end) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cyc_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cyc_nxt   = '0;
      end
    endcase
  end

  // zeroize takes priority over the next-state decode, so start+zeroize stays IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cyc      <= '0;
      r_acc      <= 1'b0;
      r_uv_base  <= '0;
      r_w_base   <= '0;
      r_dst_base <= '0;
    end else if (zeroize) begin
      r_state    <= S_IDLE;
      r_cyc      <= '0;
      r_acc      <= 1'b0;
      r_uv_base  <= '0;
      r_w_base   <= '0;
      r_dst_base <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      if (w_latch) begin
        r_acc      <= accumulate;
        r_uv_base  <= uv_base;
        r_w_base   <= w_base;
        r_dst_base <= dst_base;
      end
    end
  end

  assign w_run = (r_state == S_RUN);

  // addresses are forced to zero outside their enable window
  always_comb begin
    uv_rd_en   = w_run && (r_cyc < C_NUM);
    w_rd_en    = w_run && r_acc && (r_cyc >= C_WOFS) && (r_cyc < C_WOFS_END);
    wr_en      = w_run && (r_cyc >= w_wro) && (r_cyc < w_wre);
    uv_rd_addr = '0;
    w_rd_addr  = '0;
    wr_addr    = '0;
    if (uv_rd_en) uv_rd_addr = r_uv_base + ADDR_WIDTH'(r_cyc);
    if (w_rd_en)  w_rd_addr  = r_w_base + ADDR_WIDTH'(r_cyc - C_WOFS);
    if (wr_en)    wr_addr    = r_dst_base + ADDR_WIDTH'(r_cyc - w_wro);
  end

  assign pwm_accumulate = r_acc;
  assign rnd_en         = w_run;
  assign done           = (r_state == S_DONE);
  assign busy           = w_run || done;

endmodule

// File: tb/tb_ntt_masked_pwm_sched.sv
// Randomized bench for ntt_masked_pwm_sched; expected outputs come from a model
// indexed by cycles elapsed since the accepted start.
module tb_ntt_masked_pwm_sched;

  logic       clk;
  logic       reset_n;
  logic       zeroize;
  logic       start;
  logic       accumulate;
  logic [7:0] uv_base;
  logic [7:0] w_base;
  logic [7:0] dst_base;
  logic       uv_rd_en;
  logic [7:0] uv_rd_addr;
  logic       w_rd_en;
  logic [7:0] w_rd_addr;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic       pwm_accumulate;
  logic       rnd_en;
  logic       busy;
  logic       done;

  int unsigned n_chk;
  int unsigned n_pass;
  logic        m_acc;

  ntt_masked_pwm_sched #(
    .NUM_COEFF (256),
    .ADDR_WIDTH(8),
    .RD_LAT    (1),
    .MUL_LAT   (210),
    .ACC_LAT   (264),
    .CNT_WIDTH (10)
  ) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .zeroize       (zeroize),
    .start         (start),
    .accumulate    (accumulate),
    .uv_base       (uv_base),
    .w_base        (w_base),
    .dst_base      (dst_base),
    .uv_rd_en      (uv_rd_en),
    .uv_rd_addr    (uv_rd_addr),
    .w_rd_en       (w_rd_en),
    .w_rd_addr     (w_rd_addr),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .pwm_accumulate(pwm_accumulate),
    .rnd_en        (rnd_en),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [30:0] w_outs;
  assign w_outs = {uv_rd_en, uv_rd_addr, w_rd_en, w_rd_addr, wr_en, wr_addr,
                   pwm_accumulate, rnd_en, busy, done};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // k = cycles since the accepted start edge (cycle 1 is the first RUN cycle)
  function automatic logic [30:0] model(input int k, input bit act, input bit acc,
                                        input bit macc, input logic [7:0] uvb,
                                        input logic [7:0] wb, input logic [7:0] db);
    int lat, first, dk;
    logic uv_e, w_e, wr_e, bz, rn, dn;
    logic [7:0] ua, wa, da;
    uv_e = 0; w_e = 0; wr_e = 0; bz = 0; rn = 0; dn = 0;
    ua = 0; wa = 0; da = 0;
    if (act) begin
      lat   = acc ? 264 : 210;
      first = lat + 2;
      dk    = lat + 258;
      uv_e  = (k >= 1) && (k <= 256);
      if (uv_e) ua = 8'(int'(uvb) + k - 1);
      w_e   = acc && (k >= 212) && (k <= 467);
      if (w_e) wa = 8'(int'(wb) + k - 212);
      wr_e  = (k >= first) && (k < first + 256);
      if (wr_e) da = 8'(int'(db) + k - first);
      bz    = (k >= 1) && (k <= dk);
      rn    = (k >= 1) && (k < dk);
      dn    = (k == dk);
    end
    return {uv_e, ua, w_e, wa, wr_e, da, macc, rn, bz, dn};
  endfunction

  // rk: re-assert start, zk: zeroize, sk: async reset (cycle index, 0 = none)
  task automatic run_op(input bit acc, input logic [7:0] uvb, input logic [7:0] wb,
                        input logic [7:0] db, input int rk, input int zk, input int sk);
    int limit, nwr, ndn, dk;
    bit act;
    dk    = (acc ? 264 : 210) + 258;
    limit = (zk != 0) ? zk + 5 : (sk != 0) ? sk + 5 : dk + 1;
    nwr = 0; ndn = 0; act = 1;
    start = 1; zeroize = 0; accumulate = acc;
    uv_base = uvb; w_base = wb; dst_base = db;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (k == 1) m_acc = acc;
      if (zk != 0 && k == zk + 1) begin act = 0; m_acc = 0; end
      chk($sformatf("op_acc%0d_cyc%0d", acc, k), {1'b0, w_outs},
          {1'b0, model(k, act, acc, m_acc, uvb, wb, db)});
      if (wr_en) nwr++;
      if (done) ndn++;
      start      = (k == rk);
      zeroize    = (k == zk);
      accumulate = 1'($urandom);
      uv_base    = 8'($urandom);
      w_base     = 8'($urandom);
      dst_base   = 8'($urandom);
      if (sk != 0 && k == sk + 1) reset_n = 1;
      if (k == sk) begin
        #2 reset_n = 0;
        #1 chk("async_reset_outs", {1'b0, w_outs}, '0);
        act = 0; m_acc = 0;
      end
    end
    start = 0; zeroize = 0;
    if (zk == 0 && sk == 0) begin
      chk("write_count", nwr, 256);
      chk("done_count", ndn, 1);
    end else begin
      chk("abort_done_count", ndn, 0);
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0; m_acc = 0;
    reset_n = 0; zeroize = 0; start = 0; accumulate = 0;
    uv_base = 0; w_base = 0; dst_base = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_idle", {1'b0, w_outs}, '0);
    end

    run_op(1'b0, 8'h10, 8'($urandom), 8'h80, 0, 0, 0);
    run_op(1'b1, 8'($urandom), 8'h40, 8'($urandom), 0, 0, 0);
    run_op(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 100, 0, 0);
    run_op(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 300, 0);
    run_op(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0);
    run_op(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 50);

    start = 1; zeroize = 1; accumulate = 1;
    uv_base = 8'($urandom); w_base = 8'($urandom); dst_base = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start = 0; zeroize = 0;
      chk("start_zeroize_busy", busy, 0);
      chk("start_zeroize_outs", {1'b0, w_outs}, '0);
    end

    for (int i = 0; i < 3; i++) begin
      run_op(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
